// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store initiator: request size encoding,
// controller states, beat counter type and the beat-plan helpers.
package mem_access_pkg;

  localparam int unsigned BEAT_W = 3;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef logic [BEAT_W-1:0] beat_t;

  // Memory writes only whole words or single bytes, so halfword stores and
  // any access the memory cannot take in one piece become byte beats.
  function automatic logic needs_split(input logic [1:0] size, input logic we,
                                       input logic [1:0] addr_lo);
    return ((size == SIZE_WORD) && (addr_lo != 2'b00)) ||
           ((size == SIZE_HALF) && (we || addr_lo[0]));
  endfunction

  function automatic beat_t beat_count(input logic [1:0] size, input logic split);
    beat_t n;
    if (size == SIZE_ILL)       n = beat_t'(0);
    else if (!split)            n = beat_t'(1);
    else if (size == SIZE_WORD) n = beat_t'(4);
    else                        n = beat_t'(2);
    return n;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: sign- or zero-extends assembled load data to 32 bits.
//   size_i     : request size (SIZE_WORD/BYTE/HALF)
//   unsigned_i : 1 zero-extend, 0 sign-extend
//   data_i     : raw data, value LSB-aligned
//   result_o   : extended result (combinational)
module load_extend
  import mem_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] data_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = data_i;
    case (size_i)
      SIZE_BYTE: result_o = {{24{data_i[7] & ~unsigned_i}}, data_i[7:0]};
      SIZE_HALF: result_o = {{16{data_i[15] & ~unsigned_i}}, data_i[15:0]};
      default:   result_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between CPU datapath and a
// byte-addressed data memory that writes whole words or single bytes.
//   req_*   : valid/ready request (we, size, unsigned, addr, wdata)
//   rsp_*   : one-cycle completion strobe with extended load data / error
//   mem_*   : registered memory command (WE, dataType, A, WD); mem_RD is
//             the memory's combinational read data
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_WE,
  output logic [1:0]               mem_dataType,
  output logic [ADDRESS_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0]    mem_WD,
  input  logic [DATA_WIDTH-1:0]    mem_RD
);

  state_t                   state_q, state_d;
  beat_t                    beat_q, beat_d;
  beat_t                    nbeats_q, nbeats_d;
  logic                     split_q, split_d;
  logic                     we_q, we_d;
  logic [1:0]               size_q, size_d;
  logic                     uns_q, uns_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    lanes_q, lanes_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                     rsp_err_q, rsp_err_d;
  logic                     mem_we_q, mem_we_d;
  logic [1:0]               mem_dt_q, mem_dt_d;
  logic [ADDRESS_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [DATA_WIDTH-1:0]    mem_wd_q, mem_wd_d;

  logic [DATA_WIDTH-1:0]    asm_c;
  logic [DATA_WIDTH-1:0]    raw_c;
  logic [DATA_WIDTH-1:0]    ext_c;

  assign req_ready    = (state_q == IDLE) && !rst;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign mem_WE       = mem_we_q;
  assign mem_dataType = mem_dt_q;
  assign mem_A        = mem_a_q;
  assign mem_WD       = mem_wd_q;

  // Raw load data: byte beats merge the current beat's byte into its lane,
  // single-beat loads take mem_RD masked to the access width.
  always_comb begin
    asm_c = lanes_q;
    asm_c[{beat_q[1:0], 3'b000} +: 8] = mem_RD[7:0];
    raw_c = mem_RD;
    if (split_q) begin
      raw_c = asm_c;
    end else begin
      case (size_q)
        SIZE_BYTE: raw_c = DATA_WIDTH'(mem_RD[7:0]);
        SIZE_HALF: raw_c = DATA_WIDTH'(mem_RD[15:0]);
        default:   raw_c = mem_RD;
      endcase
    end
  end

  load_extend u_load_extend (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_i     (raw_c),
    .result_o   (ext_c)
  );

  // Next-state and next-output logic; mem_* are derived from the next
  // latched request and beat so they appear registered in each beat cycle.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    nbeats_d    = nbeats_q;
    split_d     = split_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lanes_d     = lanes_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = 1'b0;
    mem_we_d    = 1'b0;
    mem_dt_d    = 2'b00;
    mem_a_d     = '0;
    mem_wd_d    = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          uns_d    = req_unsigned;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          split_d  = needs_split(req_size, req_we, req_addr[1:0]);
          nbeats_d = beat_count(req_size, split_d);
          beat_d   = '0;
          lanes_d  = '0;
          if (req_size == SIZE_ILL) begin
            state_d     = RESP;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        lanes_d = asm_c;
        if (beat_q == beat_t'(nbeats_q - beat_t'(1))) begin
          state_d     = RESP;
          rsp_rdata_d = we_q ? '0 : ext_c;
          rsp_err_d   = 1'b0;
        end else begin
          beat_d = beat_t'(beat_q + beat_t'(1));
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rsp_valid_d = (state_d == RESP);

    if (state_d == ACCESS) begin
      mem_we_d = we_d;
      if (split_d) begin
        mem_dt_d = SIZE_BYTE;
        mem_a_d  = addr_d + ADDRESS_WIDTH'(beat_d);
        mem_wd_d = DATA_WIDTH'(wdata_d[{beat_d[1:0], 3'b000} +: 8]);
      end else begin
        mem_dt_d = size_d;
        mem_a_d  = addr_d;
        mem_wd_d = wdata_d;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      nbeats_q    <= '0;
      split_q     <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lanes_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_dt_q    <= 2'b00;
      mem_a_q     <= '0;
      mem_wd_q    <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      nbeats_q    <= nbeats_d;
      split_q     <= split_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lanes_q     <= lanes_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_we_q    <= mem_we_d;
      mem_dt_q    <= mem_dt_d;
      mem_a_q     <= mem_a_d;
      mem_wd_q    <= mem_wd_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-array memory model, a
// reference memory updated at issue time, and queues of expected memory
// beats and responses checked by an independent negedge monitor.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_WE;
  logic [1:0]  mem_dataType;
  logic [31:0] mem_A, mem_WD;
  logic [31:0] mem_RD = 32'h0;

  mem_access_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_WE(mem_WE), .mem_dataType(mem_dataType), .mem_A(mem_A),
    .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned cyc;
    logic        we;
    logic [1:0]  dt;
    logic [31:0] a;
    logic [31:0] wd;
  } beat_e;

  typedef struct {
    int unsigned cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_e;

  beat_e beat_q[$];
  rsp_e  rsp_q[$];

  logic [7:0] dut_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] dut_rd(input logic [31:0] a);
    return dut_mem.exists(a) ? dut_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory model: read data settles mid-cycle, writes commit on the edge.
  always @(negedge clk) begin
    case (mem_dataType)
      2'b00:   mem_RD = {dut_rd(mem_A + 32'd3), dut_rd(mem_A + 32'd2),
                         dut_rd(mem_A + 32'd1), dut_rd(mem_A)};
      2'b01:   mem_RD = {24'h0, dut_rd(mem_A)};
      2'b10:   mem_RD = {16'h0, dut_rd(mem_A + 32'd1), dut_rd(mem_A)};
      default: mem_RD = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_WE) begin
      case (mem_dataType)
        2'b00: for (int i = 0; i < 4; i++) dut_mem[mem_A + 32'(i)] = mem_WD[8*i +: 8];
        2'b01: dut_mem[mem_A] = mem_WD[7:0];
        2'b10: for (int i = 0; i < 2; i++) dut_mem[mem_A + 32'(i)] = mem_WD[8*i +: 8];
        default: ;
      endcase
    end
  end

  // Monitor: pops expected beats/responses by cycle stamp.
  logic [31:0] last_rdata = 32'h0;
  logic        last_err   = 1'b0;

  always @(negedge clk) begin
    rsp_e  r;
    beat_e b;
    if (rst) begin
      last_rdata = 32'h0;
      last_err   = 1'b0;
    end else begin
      while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
        r = rsp_q.pop_front();
        check("rsp_missing", 96'(cyc), 96'(r.cyc));
      end
      if (rsp_valid) begin
        check("ready_low_in_rsp", 96'(req_ready), 96'(0));
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 96'(1), 96'(0));
        end else begin
          r = rsp_q.pop_front();
          check("rsp_cycle", 96'(cyc), 96'(r.cyc));
          check("rsp_rdata", 96'(rsp_rdata), 96'(r.rdata));
          check("rsp_err", 96'(rsp_err), 96'(r.err));
          last_rdata = r.rdata;
          last_err   = r.err;
        end
      end else begin
        check("rsp_hold", 96'({rsp_rdata, rsp_err}), 96'({last_rdata, last_err}));
      end
      while (beat_q.size() > 0 && beat_q[0].cyc <= cyc) begin
        b = beat_q.pop_front();
        check("beat_cycle", 96'(cyc), 96'(b.cyc));
        if (b.we)
          check("store_beat", 96'({mem_WE, mem_dataType, mem_A, mem_WD}),
                96'({1'b1, b.dt, b.a, b.wd}));
        else
          check("load_beat", 96'({mem_WE, mem_dataType, mem_A}), 96'({1'b0, b.dt, b.a}));
      end
      if (req_ready || rsp_valid)
        check("bus_idle", 96'({mem_WE, mem_dataType, mem_A, mem_WD}), 96'(0));
    end
  end

  // Issue one request; expectations are stamped with the accept edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int          n, nb;
    logic        split;
    int unsigned e;
    logic [31:0] val;
    beat_e       b;
    rsp_e        r;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    for (int t = 0; t < 40 && !req_ready; t++) @(negedge clk);
    if (!req_ready) begin
      check("accept_timeout", 96'(0), 96'(1));
      return;
    end
    e = cyc + 1;
    if (size == 2'b11) begin
      r.cyc = e; r.rdata = 32'h0; r.err = 1'b1;
      rsp_q.push_back(r);
    end else begin
      nb    = (size == 2'b00) ? 4 : ((size == 2'b10) ? 2 : 1);
      split = ((size == 2'b00) && (addr[1:0] != 2'b00)) ||
              ((size == 2'b10) && (we || addr[0]));
      n     = split ? nb : 1;
      for (int k = 0; k < n; k++) begin
        b.cyc = e + k; b.we = we;
        b.dt  = split ? 2'b01 : size;
        b.a   = split ? addr + 32'(k) : addr;
        b.wd  = split ? {24'h0, wdata[8*k +: 8]} : wdata;
        beat_q.push_back(b);
      end
      val = 32'h0;
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_rd(addr + 32'(i));
        if (nb < 4 && !uns && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
      end
      r.cyc = e + n; r.rdata = val; r.err = 1'b0;
      rsp_q.push_back(r);
    end
    @(posedge clk);
  endtask

  task automatic gap(input int k);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic drain();
    gap(0);
    for (int t = 0; t < 60 && (rsp_q.size() > 0 || beat_q.size() > 0); t++) @(negedge clk);
    check("drain", 96'(rsp_q.size() + beat_q.size()), 96'(0));
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_ready", 96'(req_ready), 96'(0));
    check("rst_rsp", 96'({rsp_valid, rsp_rdata, rsp_err}), 96'(0));
    check("rst_mem", 96'({mem_WE, mem_dataType, mem_A, mem_WD}), 96'(0));
    rst = 1'b0;
    #1 check("ready_after_rst", 96'(req_ready), 96'(1));

    // Directed cases.
    issue(1'b1, 2'b00, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF);
    issue(1'b0, 2'b00, 1'b0, 32'h0001_0000, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h0001_0005, 32'h0000_0080);
    issue(1'b0, 2'b01, 1'b0, 32'h0001_0005, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h0001_0005, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h0001_0002, 32'h0000_A5C3);
    issue(1'b0, 2'b10, 1'b0, 32'h0001_0002, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h0001_0001, 32'h11);
    issue(1'b1, 2'b01, 1'b0, 32'h0001_0002, 32'h22);
    issue(1'b1, 2'b01, 1'b0, 32'h0001_0003, 32'h33);
    issue(1'b1, 2'b01, 1'b0, 32'h0001_0004, 32'h44);
    issue(1'b0, 2'b00, 1'b0, 32'h0001_0001, 32'h0);
    issue(1'b1, 2'b11, 1'b0, 32'h0001_0000, 32'h1234_5678);
    issue(1'b1, 2'b00, 1'b0, 32'hFFFF_FFFD, 32'h0102_0384);
    issue(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFD, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0);
    drain();

    // Reset during the second beat of a misaligned word store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0002_0001; req_wdata = 32'hCAFE_BABE;
    for (int t = 0; t < 40 && !req_ready; t++) @(negedge clk);
    check("rst_test_ready", 96'(req_ready), 96'(1));
    @(posedge clk);
    @(negedge clk) req_valid = 1'b0;
    @(posedge clk);
    #1 check("rst_beat1_active", 96'({mem_WE, mem_A}), 96'({1'b1, 32'h0002_0002}));
    #1 rst = 1'b1;
    #1 check("rst_drops_we", 96'({mem_WE, mem_A, req_ready}), 96'({1'b0, 32'h0, 1'b0}));
    ref_mem[32'h0002_0001] = 8'hBE;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_midop_rst", 96'(req_ready), 96'(1));

    // Randomized traffic, including the wrap region.
    for (int i = 0; i < 200; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                       : 32'h0001_0000 + 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 4) == 0) gap($urandom_range(0, 3));
    end
    drain();

    foreach (dut_mem[k]) check("mem_dut_vs_ref", 96'(dut_mem[k]), 96'(ref_rd(k)));
    foreach (ref_mem[k]) check("mem_ref_vs_dut", 96'(dut_rd(k)), 96'(ref_mem[k]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
